// File: rtl/ram_wr_sched_if.sv
// Requester-side write bus of the table RAM scheduler.
// Each requester owns one ADDR_BITS/DATA_BITS slice of the packed vectors.
interface ram_wr_sched_if #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/ram_wr_sched.sv
// Round-robin write-port scheduler for a dual-port table RAM.
// Sweeps the RAM to INIT_VALUE after reset or clear before serving requesters.
module ram_wr_sched #(
    parameter int                   ADDR_BITS  = 5,
    parameter int                   DATA_BITS  = 32,
    parameter int                   NUM_REQ    = 2,
    parameter logic [DATA_BITS-1:0] INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_wr_sched_if.slave        req,
    input  logic                 clear,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_din,
    output logic                 init_done,
    output logic [31:0]          wr_cnt
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW = PW + 1;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_ARB  = 1'b1;

    logic [0:0]           r_state;
    logic [ADDR_BITS-1:0] r_sweep;
    logic [PW-1:0]        r_rr;
    logic                 r_ena;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_din;
    logic                 r_init_done;
    logic [31:0]          r_cnt;

    logic                 w_serve;
    logic                 w_any;
    logic [PW-1:0]        w_idx;
    logic [IW-1:0]        w_sum;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_xfer;
    logic [PW-1:0]        w_rr_nxt;
    logic [ADDR_BITS-1:0] w_addr;
    logic [DATA_BITS-1:0] w_data;

    // Grants only once the settle cycle after a sweep has raised init_done.
    assign w_serve = (r_state == S_ARB) & r_init_done & ~clear & ~rst;

    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_sum = '0;
        w_gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr} + IW'(k);
            if (w_sum >= IW'(NUM_REQ))
                w_sum = w_sum - IW'(NUM_REQ);
            if (!w_any && req.req_valid[w_sum[PW-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_sum[PW-1:0];
            end
        end
        w_gnt[w_idx] = w_serve & w_any;
    end

    assign req.req_ready = w_gnt;
    assign w_xfer   = w_serve & w_any;
    assign w_rr_nxt = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_addr   = req.req_addr[w_idx*ADDR_BITS +: ADDR_BITS];
    assign w_data   = req.req_data[w_idx*DATA_BITS +: DATA_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_sweep     <= '0;
            r_rr        <= '0;
            r_ena       <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_init_done <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_ena <= 1'b0;
            unique case (r_state)
                S_INIT: begin
                    r_ena   <= 1'b1;
                    r_addr  <= r_sweep;
                    r_din   <= INIT_VALUE;
                    r_sweep <= r_sweep + 1'b1;
                    if (&r_sweep)
                        r_state <= S_ARB;
                end
                S_ARB: begin
                    if (!r_init_done) begin
                        r_init_done <= 1'b1;
                    end else if (clear) begin
                        r_state     <= S_INIT;
                        r_init_done <= 1'b0;
                        r_sweep     <= '0;
                    end else if (w_xfer) begin
                        r_ena  <= 1'b1;
                        r_addr <= w_addr;
                        r_din  <= w_data;
                        r_rr   <= w_rr_nxt;
                        r_cnt  <= r_cnt + 32'd1;
                    end
                end
            endcase
        end
    end

    assign ram_ena   = r_ena;
    assign ram_wea   = r_ena;
    assign ram_addr  = r_addr;
    assign ram_din   = r_din;
    assign init_done = r_init_done;
    assign wr_cnt    = r_cnt;
endmodule

// File: tb/tb_ram_wr_sched.sv
// Scoreboard bench for ram_wr_sched: a 2-requester default instance
// and a 4-requester instance with a non-zero init value.
module tb_ram_wr_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, clr_a, ena_a, wea_a, idn_a;
    logic [4:0]  addr_a;
    logic [31:0] din_a, cnt_a;
    logic        rst_b, clr_b, ena_b, wea_b, idn_b;
    logic [4:0]  addr_b;
    logic [31:0] din_b, cnt_b;

    ram_wr_sched_if #(.NUM_REQ(2), .ADDR_BITS(5), .DATA_BITS(32)) bus_a ();
    ram_wr_sched_if #(.NUM_REQ(4), .ADDR_BITS(5), .DATA_BITS(32)) bus_b ();

    ram_wr_sched #(
        .ADDR_BITS(5), .DATA_BITS(32), .NUM_REQ(2), .INIT_VALUE(32'h0)
    ) u_a (
        .clk(clk), .rst(rst_a), .req(bus_a), .clear(clr_a),
        .ram_ena(ena_a), .ram_wea(wea_a), .ram_addr(addr_a),
        .ram_din(din_a), .init_done(idn_a), .wr_cnt(cnt_a)
    );

    ram_wr_sched #(
        .ADDR_BITS(5), .DATA_BITS(32), .NUM_REQ(4), .INIT_VALUE(32'h5A)
    ) u_b (
        .clk(clk), .rst(rst_b), .req(bus_b), .clear(clr_b),
        .ram_ena(ena_b), .ram_wea(wea_b), .ram_addr(addr_b),
        .ram_din(din_b), .init_done(idn_b), .wr_cnt(cnt_b)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [36:0] sb[$];
    logic [31:0] exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_a(input logic [1:0] rdy_exp);
        logic [36:0] e;
        chk("a_ready", bus_a.req_ready, rdy_exp);
        for (int i = 0; i < 2; i++)
            if (bus_a.req_valid[i] && bus_a.req_ready[i]) begin
                sb.push_back({bus_a.req_addr[i*5 +: 5],
                              bus_a.req_data[i*32 +: 32]});
                exp_cnt++;
            end
        @(posedge clk); #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("a_ena", ena_a, 1);
            chk("a_wea", wea_a, 1);
            chk("a_addr", addr_a, e[36:32]);
            chk("a_din", din_a, e[31:0]);
        end else begin
            chk("a_idle", ena_a, 0);
            chk("a_wea_idle", wea_a, 0);
        end
        chk("a_cnt", cnt_a, exp_cnt);
    endtask

    task automatic sweep_a(input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back({5'(k), 32'h0});
            cyc_a(2'b00);
            chk("a_sweep_idn", idn_a, 0);
        end
    endtask

    task automatic cyc_b(input logic [3:0] rdy_exp);
        logic [36:0] e;
        chk("b_ready", bus_b.req_ready, rdy_exp);
        for (int i = 0; i < 4; i++)
            if (bus_b.req_valid[i] && bus_b.req_ready[i]) begin
                sb.push_back({bus_b.req_addr[i*5 +: 5],
                              bus_b.req_data[i*32 +: 32]});
                exp_cnt++;
            end
        @(posedge clk); #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("b_ena", ena_b, 1);
            chk("b_addr", addr_b, e[36:32]);
            chk("b_din", din_b, e[31:0]);
        end else begin
            chk("b_idle", ena_b, 0);
        end
        chk("b_cnt", cnt_b, exp_cnt);
    endtask

    initial begin
        rst_a = 1'b1; clr_a = 1'b0;
        rst_b = 1'b1; clr_b = 1'b0;
        bus_a.req_valid = 2'b11;
        bus_a.req_addr  = {5'd7, 5'd3};
        bus_a.req_data  = {32'hBBBB, 32'hAAAA};
        bus_b.req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            bus_b.req_addr[i*5 +: 5]   = 5'(i + 4);
            bus_b.req_data[i*32 +: 32] = 32'h1000 + 32'(i);
        end
        exp_cnt = '0;
        @(posedge clk); #1;

        // reset state
        cyc_a(2'b00);
        chk("a_rst_addr", addr_a, 0);
        chk("a_rst_din", din_a, 0);
        chk("a_rst_idn", idn_a, 0);

        // initial sweep while both requesters wait
        rst_a = 1'b0; #1;
        sweep_a(32);
        cyc_a(2'b00);
        chk("a_idn_up", idn_a, 1);

        // alternating grants
        for (int j = 0; j < 6; j++)
            cyc_a((j % 2) ? 2'b10 : 2'b01);

        // requester 1 alone, then fairness restarts at 0
        bus_a.req_valid = 2'b10; #1;
        for (int j = 0; j < 3; j++)
            cyc_a(2'b10);
        bus_a.req_valid = 2'b00; #1;
        cyc_a(2'b00);
        bus_a.req_valid = 2'b11; #1;
        cyc_a(2'b01);

        // clear with requester 0 pending
        bus_a.req_valid = 2'b01;
        clr_a = 1'b1; #1;
        cyc_a(2'b00);
        chk("a_clr_idn", idn_a, 0);
        clr_a = 1'b0; #1;
        sweep_a(32);
        cyc_a(2'b00);
        chk("a_clr_idn_up", idn_a, 1);
        cyc_a(2'b01);

        // reset in the middle of a sweep
        bus_a.req_valid = 2'b00;
        clr_a = 1'b1; #1;
        cyc_a(2'b00);
        clr_a = 1'b0; #1;
        sweep_a(11);
        rst_a = 1'b1; #1;
        exp_cnt = '0;
        cyc_a(2'b00);
        chk("a_mid_addr", addr_a, 0);
        chk("a_mid_din", din_a, 0);
        chk("a_mid_idn", idn_a, 0);
        rst_a = 1'b0; #1;
        sweep_a(32);
        cyc_a(2'b00);
        chk("a_mid_idn_up", idn_a, 1);

        // four requesters, 1 and 3 continuously valid
        exp_cnt = '0;
        cyc_b(4'b0000);
        chk("b_rst_idn", idn_b, 0);
        rst_b = 1'b0; #1;
        for (int k = 0; k < 32; k++) begin
            sb.push_back({5'(k), 32'h5A});
            cyc_b(4'b0000);
        end
        cyc_b(4'b0000);
        chk("b_idn_up", idn_b, 1);
        for (int j = 0; j < 8; j++)
            cyc_b((j % 2) ? 4'b1000 : 4'b0010);

        chk("sb_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_wr_sched.md
Name: ram_wr_sched

Overview:
- Write-port controller and scheduler for a simple dual-port table RAM: block RAM, 1 write port, 1 read port.
- Shares the single RAM write port between NUM_REQ configuration requesters using a valid/ready handshake and round-robin arbitration.
- After reset, or on demand, sweeps the whole RAM to INIT_VALUE before any requester is served.
- Sits between the control-path config writers and the match/action table RAM; the RAM read port is untouched.

Parameters:
- ADDR_BITS, 5, RAM address width; depth = 2^ADDR_BITS.
- DATA_BITS, 32, RAM word width.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- INIT_VALUE, 0, word written to every entry during a sweep.

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_BITS  packed addresses; requester i uses slice [i*ADDR_BITS +: ADDR_BITS].
- req_data  in  NUM_REQ*DATA_BITS  packed data, sliced the same way as req_addr.
- req_ready  out  NUM_REQ  one-hot grant; at most one bit set.
- clear  in  1  level request to re-run the init sweep.
- ram_ena  out  1  RAM write-port enable.
- ram_wea  out  1  RAM write enable; always equal to ram_ena.
- ram_addr  out  ADDR_BITS  RAM write address.
- ram_din  out  DATA_BITS  RAM write data.
- init_done  out  1  high when the RAM contents are valid and requesters are served.
- wr_cnt  out  32  count of accepted requester writes; wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=INIT, sweep pointer=0, rr_ptr=0.
  - All registered outputs go to 0: ram_ena, ram_wea, ram_addr, ram_din, init_done, wr_cnt.
  - req_ready=0 while rst=1.
  - rst mid-sweep or mid-arbitration aborts immediately; no partial state survives.
- All RAM-side outputs are registered. A write decided at edge N is visible on ram_* during cycle N+1, for exactly one cycle per write.
- State INIT:
  - Each cycle, drive ram_ena=ram_wea=1, ram_addr=sweep pointer, ram_din=INIT_VALUE, then increment the pointer.
  - The first sweep write appears in the cycle after the first edge with rst=0.
  - After writing address 2^ADDR_BITS-1: pointer wraps to 0, state goes to ARB, and init_done=1 coincides with ram_* idling (ena=0).
  - A sweep takes exactly 2^ADDR_BITS cycles.
  - req_ready=0 throughout; clear is ignored.
- State ARB:
  - Grant search starts at index rr_ptr and wraps modulo NUM_REQ; the first requester with req_valid set gets the grant.
  - req_ready is combinational from req_valid, rr_ptr, state and clear.
  - A transfer occurs when req_valid[i] & req_ready[i] at an edge. Next cycle: ram_ena=ram_wea=1, ram_addr=req_addr[i], ram_din=req_data[i]. Also rr_ptr=(i+1) mod NUM_REQ and wr_cnt increments by 1.
  - Throughput is one write per cycle, back-to-back.
  - If no request is valid: ram_ena=0 and rr_ptr holds.
  - ram_addr/ram_din keep their last values when idle.
- Requester rules:
  - Once req_valid is asserted, it must stay high with stable addr/data until accepted.
  - req_ready may fall without a transfer; the grant moves only after a transfer.
- Clear:
  - If clear=1 in ARB, all req_ready=0 that cycle (clear has priority over requests).
  - At that edge: state goes to INIT, init_done goes to 0, sweep pointer=0.
  - A write accepted in the previous cycle still appears on ram_* before the sweep starts, so sweep writes follow it.
- wr_cnt counts requester writes only, never sweep writes. It wraps from 0xFFFFFFFF to 0 and is not cleared by clear.

Test Plan:
- Reset, then release rst with defaults:
  - ram_ena=1 for 32 consecutive cycles with ram_addr 0..31 and ram_din=0.
  - init_done rises on the 33rd cycle.
  - req_valid=2'b11 held throughout sees req_ready=0 until init_done=1.
- After init, req_valid=2'b11 held with addr0=3/data0=0xAAAA, addr1=7/data1=0xBBBB:
  - Grants alternate 0,1,0,1 each cycle.
  - ram_* shows (3,0xAAAA), (7,0xBBBB), ... one cycle after each accept.
  - wr_cnt increments every cycle.
- Single requester 1 valid for 3 cycles:
  - 3 writes land back-to-back.
  - rr_ptr ends at 0, so a subsequent simultaneous request grants requester 0 first.
- clear=1 for one cycle while req_valid=2'b01:
  - req_ready=0 in that cycle; init_done=0 next cycle.
  - A full 32-entry sweep of 0 follows, then requester 0 is served.
  - wr_cnt is unchanged across the sweep.
- rst=1 asserted at sweep address 10:
  - All outputs are 0 on the next cycle.
  - After release, the sweep restarts at address 0 and takes the full 32 cycles.
- NUM_REQ=4, INIT_VALUE=0x5A, requesters 1 and 3 valid continuously:
  - Sweep writes 0x5A to every entry.
  - Grants then strictly alternate 1,3,1,3; requesters 0 and 2 never get req_ready.
